lcd_responder: RTL
==================

# lcd_responder

Synthesizable HD44780-subset responder for a 2×16 character display: it is the panel end of the 8-bit E/RS/RW/DB bus driven by the team's LCD controller. It samples the bus on falling E edges, decodes instructions and data writes, and maintains a 32-byte DDRAM image, an address counter and display/cursor flags. It returns busy flag, address and DDRAM data on read cycles, and exposes a readout port so testbenches and on-chip mirrors can inspect screen contents.

## Interface
- BUSY_CYCLES, 4: busy duration in clk cycles after any write except clear/home.
- CLEAR_CYCLES, 8: busy duration after clear or home; must be below one host E period.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- lcde  in  1  bus enable, asynchronous to clk; synchronized internally.
- lcdrs  in  1  0 = instruction/status, 1 = data.
- lcdrw  in  1  0 = write, 1 = read.
- lcddata  in  8  bus data from host.
- lcddata_out  out  8  read data returned to host.
- lcddata_oe  out  1  high while read data is driven.
- rd_addr  in  5  readout index: bit4 = line, bits3:0 = column.
- rd_char  out  8  DDRAM byte at rd_addr, registered, 1-cycle latency.
- cursor_addr  out  7  current address counter (AC).
- disp_on, cursor_on, blink_on  out  1 each  display-control flags.
- busy  out  1  busy flag.
- cmd_strobe  out  1  one-cycle pulse per accepted transfer.
- err_busy_write  out  1  one-cycle pulse when a write arrives while busy.

## Operation
- Reset values: DDRAM all 0x20, AC=0x00, increment mode (I/D=1), disp_on=cursor_on=blink_on=0, busy=0, lcddata_out=0x00, lcddata_oe=0, strobes 0.
- lcde, lcdrs, lcdrw and lcddata are each passed through two synchronizer flops. Edge detection uses the synchronized lcde. A transfer executes on the synchronized falling edge using the bus values sampled in the same stage.
- States: IDLE (E low) → EHIGH on rising edge → EXEC on falling edge → BUSY or IDLE.
  - Write transfers enter BUSY with a counter loaded from BUSY_CYCLES, or from CLEAR_CYCLES for clear/home.
  - Read transfers return to IDLE.
  - BUSY → IDLE when the counter reaches 0. E edges are still tracked while in BUSY.
- Instruction decode when RS=0, RW=0. The highest set bit of the data byte selects the instruction:
  - 0x80+: AC ← data[6:0].
  - 0x40+: CGRAM address; accepted, no state change.
  - 0x20+: function set; accepted, no state change.
  - 0x10+: if bit3=0, AC moves ±1 by bit2 (1 = right); a display shift is ignored.
  - 0x08+: D, C, B ← bits 2:0.
  - 0x04+: I/D ← bit1; S is ignored.
  - 0x02/0x03: AC ← 0.
  - 0x01: all DDRAM ← 0x20, AC ← 0, I/D ← 1, done in a single cycle.
  - 0x00: no-op; no busy.
- Data write (RS=1, RW=0): if AC[5:0] ≤ 0x0F, DDRAM[{AC[6],AC[3:0]}] ← data. Columns 0x10–0x27 are discarded. AC then steps per I/D.
- Status read (RS=0, RW=1): on the synchronized rising edge, lcddata_out ← {busy, AC}.
- Data read (RS=1, RW=1): on the synchronized rising edge, lcddata_out ← DDRAM byte at AC (0x20 if off-screen). AC steps on the falling edge.
- lcddata_oe is high from the rising edge to the falling edge of a read.
- AC step sequence:
  - Increment: 0x27→0x40, 0x67→0x00.
  - Decrement: 0x00→0x67, 0x40→0x27.
  - Otherwise ±1.
- Set-address operands with AC[5:0] > 0x27 load {data[6], 6'h00}.
- Writes while busy: ignored, err_busy_write pulses, busy counter unchanged. Reads are always served.
- Reset asserted mid-transfer: all state returns to reset values. The next E edge is tracked from the current synchronized level, and a falling edge seen without a prior EHIGH is ignored.

## Timing
- E falling edge at the pins → synchronized edge 2–3 clk later → EXEC one cycle after that. DDRAM, AC and flags update at the end of EXEC.
- cmd_strobe and err_busy_write are asserted during EXEC.
- busy rises in the cycle after EXEC and stays high for exactly BUSY_CYCLES or CLEAR_CYCLES cycles.
- Read data is valid 3 clk after the E rising edge at the pins.
- rd_char is registered: it reflects a write one cycle after the write's EXEC.

## Structure
- Package lcd_pkg holds:
  - instruction masks and opcodes (CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_DISP, CMD_SHIFT, CMD_FUNC, CMD_CGRAM, CMD_DDRAM);
  - line base addresses 0x00/0x40 and line end 0x27;
  - the responder state enum;
  - the AC step function.
- Sub-module lcd_ddram: 32×8 register array with a write port, single-cycle fill-with-0x20, one combinational read port (bus reads) and one registered read port (rd_char).

## Test plan
- Reset, then write 0x0C: disp_on=1, cursor_on=0, blink_on=0; busy high for exactly 4 cycles.
- Write 0x80, then data 0x32, 0x30 → rd_addr 0→0x32, rd_addr 1→0x30, cursor_addr=0x02.
- Write 0xC0, then data 0x44 → rd_addr 16=0x44, AC=0x41. Then write 0x04 and data 0x45 → rd_addr 17=0x45, AC=0x40.
- Set AC=0x27 with I/D=1, write data → no DDRAM change, AC=0x40. Set AC=0x00 with I/D=0, write data → AC=0x67.
- Write 0x01 after filling the screen → all 32 rd_char=0x20, AC=0. Write again within 8 cycles → err_busy_write pulses, DDRAM unchanged.
- Status read while busy → lcddata_out=0x80|AC with lcddata_oe high during E. After busy, a data read at AC=0x00 holding 0x41 returns 0x41 and AC becomes 0x01.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared opcodes, address constants, FSM states and helpers for the LCD responder
package lcd_pkg;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_DISP  = 8'h08;
  localparam logic [7:0] CMD_SHIFT = 8'h10;
  localparam logic [7:0] CMD_FUNC  = 8'h20;
  localparam logic [7:0] CMD_CGRAM = 8'h40;
  localparam logic [7:0] CMD_DDRAM = 8'h80;
  localparam logic [6:0] LINE0_BASE = 7'h00;
  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam logic [6:0] LINE_END   = 7'h27;
  localparam logic [7:0] BLANK      = 8'h20;
  typedef enum logic [1:0] {ST_IDLE, ST_EHIGH, ST_EXEC, ST_BUSY} state_e;
  // The opcode is the highest set bit of the instruction byte.
  function automatic logic [7:0] cmd_of(input logic [7:0] d);
    cmd_of = 8'h00;
    for (int i = 0; i < 8; i++) if (d[i]) cmd_of = 8'h01 << i;
  endfunction
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    if (inc) return ac == LINE_END ? LINE1_BASE : ac == (LINE1_BASE | LINE_END) ? LINE0_BASE : ac + 7'd1;
    return ac == LINE0_BASE ? (LINE1_BASE | LINE_END) : ac == LINE1_BASE ? LINE_END : ac - 7'd1;
  endfunction
endpackage

// File: rtl/lcd_ddram.sv
// lcd_ddram: 32-byte screen image with one-cycle blank fill, bus read port and registered readout
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       fill_i,
  input  logic       we_i,
  input  logic [4:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [4:0] raddr_i,
  output logic [7:0] rdata_o,
  input  logic [4:0] rd_addr_i,
  output logic [7:0] rd_char_o
);
  logic [7:0] mem_q [32];
  always_ff @(posedge clk) begin
    if (rst || fill_i) for (int i = 0; i < 32; i++) mem_q[i] <= BLANK;
    else if (we_i) mem_q[waddr_i] <= wdata_i;
    rd_char_o <= rst ? BLANK : mem_q[rd_addr_i];
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/lcd_responder.sv
// lcd_responder: HD44780-subset panel end of the E/RS/RW/DB bus with a 2x16 DDRAM image
module lcd_responder
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES  = 4,
  parameter int CLEAR_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcde,
  input  logic       lcdrs,
  input  logic       lcdrw,
  input  logic [7:0] lcddata,
  output logic [7:0] lcddata_out,
  output logic       lcddata_oe,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [6:0] cursor_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       busy,
  output logic       cmd_strobe,
  output logic       err_busy_write
);
  logic [10:0] s1_q, s2_q;
  logic        e_prev_q, rise, fall;
  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [6:0]  ac_q, ac_d;
  logic        id_q, id_d;
  logic [2:0]  fl_q, fl_d;
  logic        rs_q, rw_q;
  logic [7:0]  dat_q, op, ram_rd, bus_byte;
  logic [7:0]  out_q, out_d;
  logic        oe_q, oe_d;
  logic        exec, wr_ok, ins, clr, home, dwr, drd, load;
  // Synchronizers run through reset so edge tracking resumes from the live E level.
  always_ff @(posedge clk) begin
    s1_q     <= {lcde, lcdrs, lcdrw, lcddata};
    s2_q     <= s1_q;
    e_prev_q <= s2_q[10];
  end
  assign rise = s2_q[10] & ~e_prev_q;
  assign fall = ~s2_q[10] & e_prev_q;
  assign exec  = state_q == ST_EXEC;
  assign op    = cmd_of(dat_q);
  assign wr_ok = exec & ~rw_q & ~busy;
  assign ins   = wr_ok & ~rs_q;
  assign clr   = ins & op == CMD_CLEAR;
  assign home  = ins & (op == CMD_CLEAR | op == CMD_HOME);
  assign dwr   = wr_ok & rs_q;
  assign drd   = exec & rw_q & rs_q;
  assign load  = dwr | (ins & op != 8'h00);
  assign bus_byte = ac_q[5:4] != 2'b00 ? BLANK : ram_rd;
  always_comb begin
    cnt_d = load ? 8'(home ? CLEAR_CYCLES : BUSY_CYCLES) : busy ? cnt_q - 8'd1 : cnt_q;
    ac_d  = ins && op == CMD_DDRAM ? (dat_q[5:0] > LINE_END[5:0] ? {dat_q[6], 6'h00} : dat_q[6:0])
          : home ? LINE0_BASE
          : ins && op == CMD_SHIFT && !dat_q[3] ? ac_step(ac_q, dat_q[2])
          : dwr || drd ? ac_step(ac_q, id_q) : ac_q;
    id_d  = clr ? 1'b1 : ins && op == CMD_ENTRY ? dat_q[1] : id_q;
    fl_d  = ins && op == CMD_DISP ? dat_q[2:0] : fl_q;
    oe_d  = rise && s2_q[8] ? 1'b1 : fall ? 1'b0 : oe_q;
    out_d = rise && s2_q[8] ? (s2_q[9] ? bus_byte : {busy, ac_q}) : out_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      ac_q  <= LINE0_BASE;
      id_q  <= 1'b1;
      fl_q  <= '0;
      out_q <= '0;
      oe_q  <= 1'b0;
      rs_q  <= 1'b0;
      rw_q  <= 1'b0;
      dat_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ac_q  <= ac_d;
      id_q  <= id_d;
      fl_q  <= fl_d;
      out_q <= out_d;
      oe_q  <= oe_d;
      if (fall) {rs_q, rw_q, dat_q} <= s2_q[9:0];
    end
  end
  always_ff @(posedge clk) state_q <= reset ? ST_IDLE : state_d;
  // A falling edge only executes when the matching rising edge was seen.
  always_comb begin
    state_d = state_q == ST_EHIGH ? (fall ? ST_EXEC : ST_EHIGH)
            : rise ? ST_EHIGH
            : state_q == ST_IDLE ? ST_IDLE
            : cnt_d != 8'd0 ? ST_BUSY : ST_IDLE;
  end
  always_comb begin
    busy           = cnt_q != 8'd0;
    cmd_strobe     = exec & (rw_q | ~busy);
    err_busy_write = exec & ~rw_q & busy;
  end
  assign lcddata_out = out_q;
  assign lcddata_oe  = oe_q;
  assign cursor_addr = ac_q;
  assign {disp_on, cursor_on, blink_on} = fl_q;
  lcd_ddram u_ram (
    .clk(clk),
    .rst(reset),
    .fill_i(clr),
    .we_i(dwr & ac_q[5:4] == 2'b00),
    .waddr_i({ac_q[6], ac_q[3:0]}),
    .wdata_i(dat_q),
    .raddr_i({ac_q[6], ac_q[3:0]}),
    .rdata_o(ram_rd),
    .rd_addr_i(rd_addr),
    .rd_char_o(rd_char)
  );
endmodule
